// File: rtl/match_req_dispatcher.sv
// match_req_dispatcher
// Accepts one lazy window (LAZY_LEN candidate offsets, per-lane channel route map, tag)
// and multicasts each lane to every match-PE request channel whose route bit is set.
// Each channel has its own valid/ready handshake; a new window is accepted only after
// every channel has drained.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   in_valid       window valid
//   in_ready       dispatcher can accept a window (high only in IDLE)
//   in_offset      lane i offset at [i*OFFSET_BITS +: OFFSET_BITS]
//   in_route_map   bit i*NUM_CH+j: lane i goes to channel j
//   in_tag         window tag
//   out_valid      per-channel request valid
//   out_ready      per-channel request ready
//   out_offset     per-channel offset of the selected lane
//   out_lane       per-channel lane index of the request
//   out_tag        per-channel tag of the current window
//   out_last       per-channel last request of this window
//   err_unrouted   sticky: some accepted lane had no route bit set
module match_req_dispatcher #(
    parameter int unsigned LAZY_LEN    = 4,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned OFFSET_BITS = 20,
    parameter int unsigned TAG_BITS    = 8,
    localparam int unsigned LANE_BITS  = (LAZY_LEN > 1) ? $clog2(LAZY_LEN) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LAZY_LEN*OFFSET_BITS-1:0] in_offset,
    input  logic [LAZY_LEN*NUM_CH-1:0]      in_route_map,
    input  logic [TAG_BITS-1:0]             in_tag,
    output logic [NUM_CH-1:0]               out_valid,
    input  logic [NUM_CH-1:0]               out_ready,
    output logic [NUM_CH*OFFSET_BITS-1:0]   out_offset,
    output logic [NUM_CH*LANE_BITS-1:0]     out_lane,
    output logic [NUM_CH*TAG_BITS-1:0]      out_tag,
    output logic [NUM_CH-1:0]               out_last,
    output logic                            err_unrouted
);

    localparam int unsigned PEND_BITS = LAZY_LEN * NUM_CH;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_DISPATCH = 1'b1
    } state_t;

    state_t                          state;
    state_t                          state_nxt;
    logic [PEND_BITS-1:0]            pend;
    logic [PEND_BITS-1:0]            pend_nxt;
    logic [OFFSET_BITS-1:0]          off_q [LAZY_LEN];
    logic [TAG_BITS-1:0]             tag_q;
    logic                            err_q;
    logic                            accept;
    logic                            any_unrouted;
    logic [NUM_CH-1:0][LANE_BITS-1:0] sel;
    logic [NUM_CH-1:0]               ch_valid;
    logic [NUM_CH-1:0]               ch_multi;

    // Per-channel lowest pending lane; ch_multi flags two or more pending bits.
    always_comb begin
        sel      = '0;
        ch_valid = '0;
        ch_multi = '0;
        for (int j = 0; j < int'(NUM_CH); j++) begin
            // Scan high-to-low so the lowest set lane is the last one written.
            for (int i = int'(LAZY_LEN) - 1; i >= 0; i--) begin
                if (pend[i*int'(NUM_CH) + j]) begin
                    if (ch_valid[j]) begin
                        ch_multi[j] = 1'b1;
                    end
                    ch_valid[j] = 1'b1;
                    sel[j]      = LANE_BITS'(i);
                end
            end
        end
    end

    // A lane with no route bit at all is flagged when the window is taken.
    always_comb begin
        any_unrouted = 1'b0;
        for (int i = 0; i < int'(LAZY_LEN); i++) begin
            if (in_route_map[i*int'(NUM_CH) +: NUM_CH] == '0) begin
                any_unrouted = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, window accept and pending-bit retirement.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    pend_nxt = in_route_map;
                    // An all-zero map is consumed without leaving IDLE.
                    if (|in_route_map) begin
                        state_nxt = ST_DISPATCH;
                    end
                end
            end
            ST_DISPATCH: begin
                for (int j = 0; j < int'(NUM_CH); j++) begin
                    if (ch_valid[j] && out_ready[j]) begin
                        pend_nxt[int'(sel[j])*int'(NUM_CH) + j] = 1'b0;
                    end
                end
                if (pend_nxt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                pend_nxt  = '0;
            end
        endcase
    end

    // Window payload, pending map and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= '0;
            tag_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < int'(LAZY_LEN); i++) begin
                off_q[i] <= '0;
            end
        end else begin
            pend <= pend_nxt;
            if (accept) begin
                tag_q <= in_tag;
                err_q <= err_q | any_unrouted;
                for (int i = 0; i < int'(LAZY_LEN); i++) begin
                    off_q[i] <= in_offset[i*int'(OFFSET_BITS) +: OFFSET_BITS];
                end
            end
        end
    end

    // Outputs are decoded purely from registered state.
    always_comb begin
        out_offset = '0;
        out_lane   = '0;
        out_tag    = '0;
        for (int j = 0; j < int'(NUM_CH); j++) begin
            out_offset[j*int'(OFFSET_BITS) +: OFFSET_BITS] = off_q[sel[j]];
            out_lane[j*int'(LANE_BITS) +: LANE_BITS]       = sel[j];
            out_tag[j*int'(TAG_BITS) +: TAG_BITS]          = tag_q;
        end
    end

    assign in_ready     = (state == ST_IDLE);
    assign out_valid    = ch_valid;
    assign out_last     = ch_valid & ~ch_multi;
    assign err_unrouted = err_q;

endmodule

// File: tb/tb_match_req_dispatcher.sv
// Testbench for match_req_dispatcher: directed windows plus random traffic, checked
// against a queue-based reference model (per-channel FIFO of lanes still to issue).
module tb_match_req_dispatcher;

    localparam int unsigned LL = 4;
    localparam int unsigned NC = 4;
    localparam int unsigned OB = 20;
    localparam int unsigned TB = 8;
    localparam int unsigned LB = 2;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [LL*OB-1:0]  in_offset;
    logic [LL*NC-1:0]  in_route_map;
    logic [TB-1:0]     in_tag;
    logic [NC-1:0]     out_valid;
    logic [NC-1:0]     out_ready;
    logic [NC*OB-1:0]  out_offset;
    logic [NC*LB-1:0]  out_lane;
    logic [NC*TB-1:0]  out_tag;
    logic [NC-1:0]     out_last;
    logic              err_unrouted;

    match_req_dispatcher dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_offset    (in_offset),
        .in_route_map (in_route_map),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_offset   (out_offset),
        .out_lane     (out_lane),
        .out_tag      (out_tag),
        .out_last     (out_last),
        .err_unrouted (err_unrouted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err    = 0;
    int n_checks = 0;
    int low_cnt  = 0;

    // Reference model state.
    int          q [NC][$];
    logic [OB-1:0] m_off [LL];
    logic [TB-1:0] m_tag;
    bit          m_busy;
    bit          m_err;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < int'(NC); j++) q[j].delete();
        m_busy = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge(input logic iv, input logic [LL*OB-1:0] off,
                              input logic [LL*NC-1:0] map, input logic [TB-1:0] tg,
                              input logic [NC-1:0] rdy);
        if (!m_busy) begin
            if (iv) begin
                m_tag = tg;
                for (int i = 0; i < int'(LL); i++) begin
                    m_off[i] = off[i*OB +: OB];
                    if (map[i*NC +: NC] == '0) m_err = 1'b1;
                end
                for (int j = 0; j < int'(NC); j++)
                    for (int i = 0; i < int'(LL); i++)
                        if (map[i*NC + j]) q[j].push_back(i);
            end
        end else begin
            for (int j = 0; j < int'(NC); j++)
                if (q[j].size() > 0 && rdy[j]) void'(q[j].pop_front());
        end
        m_busy = 1'b0;
        for (int j = 0; j < int'(NC); j++)
            if (q[j].size() > 0) m_busy = 1'b1;
    endtask

    task automatic check_outputs();
        bit v;
        chk("in_ready", in_ready, !m_busy);
        chk("err_unrouted", err_unrouted, m_err);
        for (int j = 0; j < int'(NC); j++) begin
            v = q[j].size() > 0;
            chk($sformatf("out_valid[%0d]", j), out_valid[j], v);
            chk($sformatf("out_last[%0d]", j), out_last[j], v && q[j].size() == 1);
            if (v) begin
                chk($sformatf("out_lane[%0d]", j), out_lane[j*LB +: LB], q[j][0]);
                chk($sformatf("out_offset[%0d]", j), out_offset[j*OB +: OB], m_off[q[j][0]]);
                chk($sformatf("out_tag[%0d]", j), out_tag[j*TB +: TB], m_tag);
            end
        end
    endtask

    // One clock cycle: drive at negedge, check, advance model at posedge.
    task automatic cycle(input logic iv, input logic [LL*OB-1:0] off,
                         input logic [LL*NC-1:0] map, input logic [TB-1:0] tg,
                         input logic [NC-1:0] rdy);
        in_valid     = iv;
        in_offset    = off;
        in_route_map = map;
        in_tag       = tg;
        out_ready    = rdy;
        check_outputs();
        if (!in_ready) low_cnt++;
        @(posedge clk);
        model_edge(iv, off, map, tg, rdy);
        @(negedge clk);
    endtask

    function automatic logic [LL*OB-1:0] rnd_off();
        return (LL*OB)'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic drain(input int budget);
        for (int k = 0; k < budget && m_busy; k++)
            cycle(1'b0, rnd_off(), '0, '0, '1);
        chk("drain_timeout", m_busy, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, '0);
        chk("rst_out_last", out_last, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_err", err_unrouted, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int max_pop(input logic [LL*NC-1:0] map);
        int cnt [NC];
        int mx = 0;
        for (int j = 0; j < int'(NC); j++) cnt[j] = 0;
        for (int i = 0; i < int'(LL*NC); i++) if (map[i]) cnt[i % NC]++;
        for (int j = 0; j < int'(NC); j++) if (cnt[j] > mx) mx = cnt[j];
        return mx;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [LL*NC-1:0] map;
        int               accepted;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_offset    = '0;
        in_route_map = '0;
        in_tag       = '0;
        out_ready    = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, '0);
        chk("reset_err", err_unrouted, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: lane0 -> ch0..2, lanes1..3 -> ch3, all ready.
        low_cnt = 0;
        cycle(1'b1, rnd_off(), 16'h8887, 8'h5A, '1);
        drain(20);
        chk("t1_ready_low_cycles", low_cnt, 3);
        chk("t1_in_ready_after", in_ready, 1'b1);

        // T2: same window with ch3 stalled for 5 cycles.
        low_cnt = 0;
        cycle(1'b1, rnd_off(), 16'h8887, 8'hA5, '1);
        repeat (5) cycle(1'b0, '0, '0, '0, 4'b0111);
        drain(20);
        chk("t2_ready_low_cycles", low_cnt, 8);

        // T3: empty window consumed silently, error sticky across later windows.
        low_cnt = 0;
        cycle(1'b1, rnd_off(), 16'h0000, 8'h33, '1);
        cycle(1'b0, '0, '0, '0, '1);
        chk("t3_ready_never_low", low_cnt, 0);
        chk("t3_err_set", err_unrouted, 1'b1);
        cycle(1'b1, rnd_off(), 16'h1248, 8'h44, '1);
        drain(20);
        chk("t3_err_sticky", err_unrouted, 1'b1);
        do_reset();

        // T4: lane2 unrouted, others routed.
        cycle(1'b1, rnd_off(), 16'h8012, 8'h77, '1);
        drain(20);
        chk("t4_err_set", err_unrouted, 1'b1);

        // T5: back-to-back one-bit-per-lane windows, junk in_valid during dispatch.
        for (int w = 0; w < 8; w++) begin
            map = '0;
            for (int i = 0; i < int'(LL); i++) map[i*NC + int'($urandom_range(NC-1))] = 1'b1;
            low_cnt = 0;
            cycle(1'b1, rnd_off(), map, 8'(w + 8'h10), '1);
            for (int k = 0; k < 20 && m_busy; k++)
                cycle(1'b1, rnd_off(), 16'(~map), 8'hEE, '1);
            chk($sformatf("t5_ready_low_w%0d", w), low_cnt, max_pop(map));
        end

        // T6: reset while ch1 is stalled mid-window, then a clean window.
        do_reset();
        cycle(1'b1, rnd_off(), 16'h2223, 8'h66, '1);
        cycle(1'b0, '0, '0, '0, 4'b1101);
        cycle(1'b0, '0, '0, '0, 4'b1101);
        chk("t6_ch1_stalled", out_valid[1], 1'b1);
        do_reset();
        cycle(1'b1, rnd_off(), 16'h4321, 8'h99, '1);
        drain(20);

        // Random traffic.
        accepted = 0;
        for (int c = 0; c < 500; c++) begin
            map = 16'($urandom());
            if ($urandom_range(7) == 0) map[int'($urandom_range(LL-1))*NC +: NC] = '0;
            if (!m_busy && in_valid == 1'b0) accepted++;
            cycle(1'($urandom_range(1)), rnd_off(), map, 8'($urandom()),
                  4'($urandom()));
        end
        drain(200);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
